// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and sizing helpers for serial_adder_n.
// Provides the FSM state enum, the per-operation step count and counter width.
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of digit steps per operation.
    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    // Step counter width; never narrower than one bit.
    function automatic int cnt_w(input int width, input int digit);
        int n;
        n = $clog2(width / digit);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/serial_adder_n_digit.sv
// digit_adder: combinational ripple of DIGIT full-adder cells.
// Ports: a_i/b_i operand digits, c_i carry-in; s_o sum digit,
// c_o carry-out, cmsb_o carry into the top bit of the digit.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o,
    output logic             cmsb_o
);

    logic [DIGIT:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        logic p;
        assign p        = a_i[i] ^ b_i[i];
        assign s_o[i]   = p ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & p);
    end

    assign c_o    = c[DIGIT];
    assign cmsb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle add/subtract, DIGIT bits per clock, LSD first.
// Ports: start/SUB/A/B/CI request; busy, done pulse, S result, CO carry, OV overflow.
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OV
);

    localparam int NSTEP = steps(WIDTH, DIGIT);
    localparam int CW    = cnt_w(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    if (WIDTH < 2) begin : g_chk_w
        $error("serial_adder_n: WIDTH must be at least 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_chk_d
        $error("serial_adder_n: DIGIT must divide WIDTH");
    end

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ov_q;

    logic [DIGIT-1:0] sum_d;
    logic             carry_d;
    logic             cmsb_d;
    logic [WIDTH-1:0] acc_d;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_i    (opa_q[DIGIT-1:0]),
        .b_i    (opb_q[DIGIT-1:0]),
        .c_i    (carry_q),
        .s_o    (sum_d),
        .c_o    (carry_d),
        .cmsb_o (cmsb_d)
    );

    // New digit enters at the top; after NSTEP shifts the LSD sits at bit 0.
    assign acc_d = (acc_q >> DIGIT)
                 | (WIDTH'(sum_d) << (WIDTH - DIGIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        opa_q   <= A;
                        opb_q   <= SUB ? ~B : B;
                        carry_q <= SUB ? ~CI : CI;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    opa_q   <= opa_q >> DIGIT;
                    opb_q   <= opb_q >> DIGIT;
                    carry_q <= carry_d;
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // Final digit holds the MSB, so its internal
                        // top-bit carry is the carry into the MSB.
                        s_q     <= acc_d;
                        co_q    <= carry_d;
                        ov_q    <= carry_d ^ cmsb_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign CO   = co_q;
    assign OV   = ov_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: scoreboard bench over five serial_adder_n configurations.
// Stimulus pushes expected results; a negedge monitor pops on each done.
module tb_serial_adder_n;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] st;
    logic       sub;
    logic       ci;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] bsy;
    logic [4:0] dn;
    logic [4:0] co;
    logic [4:0] ov;
    logic [7:0] s0, s1, s2;
    logic [3:0] s3, s4;

    int total = 0;
    int pass  = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u81 (
        .clk(clk), .rst(rst), .start(st[0]), .SUB(sub), .A(a), .B(b),
        .CI(ci), .busy(bsy[0]), .done(dn[0]), .S(s0), .CO(co[0]), .OV(ov[0])
    );
    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u84 (
        .clk(clk), .rst(rst), .start(st[1]), .SUB(sub), .A(a), .B(b),
        .CI(ci), .busy(bsy[1]), .done(dn[1]), .S(s1), .CO(co[1]), .OV(ov[1])
    );
    serial_adder_n #(.WIDTH(8), .DIGIT(2)) u82 (
        .clk(clk), .rst(rst), .start(st[2]), .SUB(sub), .A(a), .B(b),
        .CI(ci), .busy(bsy[2]), .done(dn[2]), .S(s2), .CO(co[2]), .OV(ov[2])
    );
    serial_adder_n #(.WIDTH(4), .DIGIT(1)) u41 (
        .clk(clk), .rst(rst), .start(st[3]), .SUB(sub), .A(a[3:0]),
        .B(b[3:0]), .CI(ci), .busy(bsy[3]), .done(dn[3]), .S(s3),
        .CO(co[3]), .OV(ov[3])
    );
    serial_adder_n #(.WIDTH(4), .DIGIT(2)) u42 (
        .clk(clk), .rst(rst), .start(st[4]), .SUB(sub), .A(a[3:0]),
        .B(b[3:0]), .CI(ci), .busy(bsy[4]), .done(dn[4]), .S(s4),
        .CO(co[4]), .OV(ov[4])
    );

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act == expv) pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    function automatic logic [7:0] s_of(input int i);
        case (i)
            0:       return s0;
            1:       return s1;
            2:       return s2;
            3:       return {4'h0, s3};
            default: return {4'h0, s4};
        endcase
    endfunction

    // Reference: {CO,S} = A + (SUB ? ~B : B) + (SUB ? ~CI : CI), width w.
    function automatic exp_t model(input int w, input int ta, input int tb,
                                   input int tci, input int tsub);
        exp_t e;
        int bb, cc, mask, lmask, sum, low;
        bb    = tsub != 0 ? ~tb : tb;
        cc    = tsub != 0 ? 1 - tci : tci;
        mask  = (1 << w) - 1;
        lmask = (1 << (w - 1)) - 1;
        sum   = (ta & mask) + (bb & mask) + cc;
        low   = (ta & lmask) + (bb & lmask) + cc;
        e.s   = 8'(sum & mask);
        e.co  = 1'((sum >> w) & 1);
        e.ov  = e.co ^ 1'((low >> (w - 1)) & 1);
        return e;
    endfunction

    task automatic push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            3:       q3.push_back(e);
            default: q4.push_back(e);
        endcase
    endtask

    task automatic pop(input int i, output exp_t e, output logic ok);
        ok = 1'b1;
        e  = '0;
        case (i)
            0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            2:       if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
            3:       if (q3.size() > 0) e = q3.pop_front(); else ok = 1'b0;
            default: if (q4.size() > 0) e = q4.pop_front(); else ok = 1'b0;
        endcase
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        logic ok;
        for (int i = 0; i < 5; i++) begin
            if (dn[i] === 1'b1) begin
                pop(i, e, ok);
                if (!ok) begin
                    total++;
                    $display("FAIL done%0d: got unexpected done, expected none",
                             i);
                end else begin
                    chk($sformatf("S%0d", i), int'(s_of(i)), int'(e.s));
                    chk($sformatf("CO%0d", i), int'(co[i]), int'(e.co));
                    chk($sformatf("OV%0d", i), int'(ov[i]), int'(e.ov));
                end
            end
        end
    end

    task automatic issue(input logic [4:0] m, input logic [7:0] ta,
                         input logic [7:0] tb, input logic tci,
                         input logic tsub);
        @(negedge clk);
        a   = ta;
        b   = tb;
        ci  = tci;
        sub = tsub;
        st  = m;
        @(posedge clk);
        #1 st = '0;
        for (int i = 0; i < 5; i++)
            if (m[i]) chk($sformatf("busy_rise%0d", i), int'(bsy[i]), 1);
    endtask

    // Counts edges from the current point until done is seen.
    task automatic wait_done(input int i, input int expn);
        int  n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (dn[i]) seen = 1'b1;
        end
        chk($sformatf("latency%0d", i), n, expn);
        chk($sformatf("busy_fall%0d", i), int'(bsy[i]), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        st  = '0;
        a   = '0;
        b   = '0;
        ci  = 1'b0;
        sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(bsy), 0);
        chk("rst_done", int'(dn), 0);
        chk("rst_S", int'({s0, s1, s2, s3, s4}), 0);
        chk("rst_CO", int'(co), 0);
        chk("rst_OV", int'(ov), 0);
        rst = 1'b0;

        push(0, '{8'h4C, 1'b0, 1'b0});
        issue(5'b00001, 8'h3C, 8'h0F, 1'b1, 1'b0);
        wait_done(0, 8);

        push(1, '{8'h80, 1'b0, 1'b1});
        issue(5'b00010, 8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(1, 2);
        push(1, '{8'h00, 1'b1, 1'b0});
        issue(5'b00010, 8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(1, 2);

        push(2, '{8'hFE, 1'b0, 1'b0});
        issue(5'b00100, 8'h05, 8'h07, 1'b0, 1'b1);
        wait_done(2, 4);
        push(2, '{8'h7F, 1'b1, 1'b1});
        issue(5'b00100, 8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(2, 4);

        push(0, '{8'h30, 1'b0, 1'b0});
        issue(5'b00001, 8'h10, 8'h20, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a  = 8'hFF;
        b  = 8'hFF;
        st = 5'b00001;
        @(posedge clk);
        #1 st = '0;
        chk("hold_busy", int'(bsy[0]), 1);
        chk("hold_S", int'(s0), 8'h4C);
        wait_done(0, 4);

        push(0, '{8'h03, 1'b0, 1'b0});
        issue(5'b00001, 8'h01, 8'h02, 1'b0, 1'b0);
        wait_done(0, 8);
        a   = 8'h40;
        b   = 8'h02;
        ci  = 1'b0;
        sub = 1'b1;
        st  = 5'b00001;
        push(0, '{8'h3E, 1'b1, 1'b0});
        @(posedge clk);
        #1 st = '0;
        chk("b2b_busy", int'(bsy[0]), 1);
        chk("b2b_done_low", int'(dn[0]), 0);
        wait_done(0, 8);

        issue(5'b00001, 8'h11, 8'h22, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", int'(bsy[0]), 0);
        chk("abort_done", int'(dn[0]), 0);
        chk("abort_S", int'(s0), 0);
        chk("abort_CO", int'(co[0]), 0);
        chk("abort_OV", int'(ov[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_idle", int'(bsy[0]), 0);
        push(0, '{8'h33, 1'b0, 1'b0});
        issue(5'b00001, 8'h11, 8'h22, 1'b0, 1'b0);
        wait_done(0, 8);

        for (int ta = 0; ta < 16; ta++)
            for (int tb = 0; tb < 16; tb++)
                for (int tc = 0; tc < 2; tc++)
                    for (int ts = 0; ts < 2; ts++) begin
                        push(3, model(4, ta, tb, tc, ts));
                        push(4, model(4, ta, tb, tc, ts));
                        issue(5'b11000, 8'(ta), 8'(tb), 1'(tc), 1'(ts));
                        wait_done(3, 4);
                    end

        repeat (4) @(negedge clk);
        chk("queues_empty",
            q0.size() + q1.size() + q2.size() + q3.size() + q4.size(), 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised multi-cycle adder/subtractor built around a small combinational digit adder. It adds or subtracts two WIDTH-bit operands plus a carry-in, processing DIGIT bits per clock, least-significant digit first. A start/busy/done handshake controls each operation, and the block reports carry-out and signed overflow. It sits wherever the design needs wide arithmetic without a full-width ripple chain on the critical path.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only when busy = 0.
- SUB  input  1  0 = add, 1 = subtract; sampled with start.
- A  input  WIDTH  first operand; sampled with start.
- B  input  WIDTH  second operand; sampled with start.
- CI  input  1  carry-in (add) or borrow-in (subtract); sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results update.
- S  output  WIDTH  result, held until the next completion.
- CO  output  1  carry-out; for subtract, 1 = no borrow.
- OV  output  1  two's-complement overflow.

## Operation
- Reset is one clock domain, asynchronous, active-high. While rst = 1: state = IDLE, counter = 0, busy = 0, done = 0, S = 0, CO = 0, OV = 0, internal shift registers = 0.
- States:
  - IDLE → RUN when start = 1.
  - RUN → IDLE when step counter = WIDTH/DIGIT − 1 and that step completes.
- Latch on accept:
  - opA ← A.
  - opB ← SUB ? ~B : B.
  - carry ← SUB ? ~CI : CI.
- Arithmetic:
  - Add: {CO, S} = A + B + CI.
  - Subtract: {CO, S} = A + ~B + ~CI, i.e. A − B − CI, modulo 2^WIDTH.
- Each RUN step:
  - Digit adder combines opA[DIGIT−1:0], opB[DIGIT−1:0] and carry.
  - Sum digit is shifted into the top of the accumulator; opA and opB shift right by DIGIT.
  - carry ← digit carry-out; counter increments.
  - On the final step, the carry into the MSB position is captured for OV.
- Completion, on the final step edge:
  - S ← full accumulator.
  - CO ← final carry.
  - OV ← carry into MSB XOR final carry.
  - done ← 1 for exactly one cycle.
- Output stability: S, CO and OV change only at completion or reset. Partial sums are never visible.
- start while busy = 1 is ignored; there is no queueing.
- A start asserted in the same cycle done is high is accepted (back-to-back operation).
- Asserting rst mid-operation aborts it. No done pulse is produced and the outputs clear.
- Wrap-around: results are modulo 2^WIDTH. Overflow is reported only through CO and OV.

## Timing
- N = WIDTH/DIGIT.
- Start sampled at edge k; busy = 1 after edge k.
- RUN occupies edges k+1 … k+N.
- After edge k+N: busy = 0, done = 1, and S/CO/OV are valid.
- After edge k+N+1: done = 0.
- Latency from accept to results is N cycles. With back-to-back starts, throughput is one operation per N+1 cycles.
- Operand inputs are don't-care except in the accept cycle.

## Structure
- Shared package serial_adder_pkg holds:
  - state enum {IDLE, RUN};
  - a function computing the step count WIDTH/DIGIT;
  - the counter-width function $clog2(WIDTH/DIGIT) with a minimum of 1.
- Sub-module digit_adder (parameter DIGIT): combinational ripple of DIGIT 1-bit full adder cells. Outputs are the DIGIT-bit sum, the carry-out, and the carry into the top bit (used for OV).
- Top level holds the FSM, counter, shift registers, output registers and parameter checks (elaboration error if WIDTH % DIGIT ≠ 0).

## Test plan
- WIDTH=8, DIGIT=1: A=0x3C, B=0x0F, CI=1, SUB=0 → after 8 cycles S=0x4C, CO=0, OV=0, done pulses once.
- WIDTH=8, DIGIT=4: A=0x7F, B=0x01, CI=0, SUB=0 → after 2 cycles S=0x80, CO=0, OV=1; A=0xFF, B=0x01 → S=0x00, CO=1, OV=0.
- Subtract, WIDTH=8, DIGIT=2:
  - A=0x05, B=0x07, CI=0 → S=0xFE, CO=0.
  - A=0x80, B=0x01, CI=0 → S=0x7F, CO=1, OV=1.
- Handshake: start pulsed again mid-RUN → ignored and S unchanged until the first completion; start held during the done cycle → second operation accepted, busy rises on the next edge.
- Reset mid-operation: rst asserted on step 3 of 8 → busy, done, S, CO and OV are 0 immediately; no done follows; a fresh start then completes correctly.
- Exhaustive sweep, WIDTH=4, DIGIT=1 and DIGIT=2: all A, B, CI, SUB combinations checked against the reference model {CO,S} = A ± B ± CI and the OV rule.
